bias_bank: RTL and testbench

Clocked, writable bias store that replaces the fixed two-set bias mux of the GAN datapath. Holds N_SETS selectable bias sets for each of the four layers (generator L2/L3, discriminator L2/L3) in signed Q8.24. Accepts runtime word writes from the host/loader. Streams a requested layer/set to the MAC pipeline one word per handshake.

---
 rtl/bias_pkg.sv | 36 +++
 rtl/bias_stream_fsm.sv | 118 +++++++++++
 rtl/bias_bank.sv | 116 +++++++++++
 tb/tb_bias_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared constants for the GAN bias store: layer indices, per-layer lengths,
// the Q8.24 bias type and the trained preload sets.
package bias_pkg;

    localparam int BIAS_W     = 32;
    localparam int NUM_LAYERS = 4;
    localparam int NUM_SETS   = 4;
    localparam int MAX_WORDS  = 9;

    localparam int G_L2 = 0;
    localparam int G_L3 = 1;
    localparam int D_L2 = 2;
    localparam int D_L3 = 3;

    typedef logic signed [BIAS_W-1:0] bias_t;

    localparam int LAYER_LEN [NUM_LAYERS] = '{3, 9, 3, 1};

    // Unused tail words of the shorter layers are padded with zero.
    localparam bias_t BIAS_SET0 [NUM_LAYERS][MAX_WORDS] = '{
        '{32'h01A1B252, 32'h00EF368B, 32'h00414304, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
        '{32'h00C2A1F0, 32'hFFB31C44, 32'h0051E2A9, 32'hFF8E0D13, 32'h0020C49C,
          32'h00F1A9FB, 32'hFFD70A3E, 32'h003B645A, 32'hFFE147AE},
        '{32'hFF6A7EFA, 32'h0091EB85, 32'h00147AE1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
        '{32'h0028F5C3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}
    };

    localparam bias_t BIAS_SET1 [NUM_LAYERS][MAX_WORDS] = '{
        '{32'h0199999A, 32'h00E66666, 32'h00400000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
        '{32'h00B33333, 32'hFFA66666, 32'h004CCCCD, 32'hFF999999, 32'h00199999,
          32'h00F33333, 32'hFFCCCCCD, 32'h00333333, 32'hFFE66666},
        '{32'hFF733333, 32'h008CCCCD, 32'h000CCCCD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
        '{32'h00266666, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}
    };

endpackage

// File: rtl/bias_stream_fsm.sv
// Request checker and word streamer for bias_bank: validates a layer/set/len
// request, then presents one registered bias word per consumer handshake.
//
// state     | meaning
// ST_IDLE   | req_ready high, waiting for a request
// ST_STREAM | b_valid high, presenting word cnt of the latched layer/set
module bias_stream_fsm
    import bias_pkg::*;
#(
    parameter int  WIDTH  = BIAS_W,
    parameter int  N_SETS = NUM_SETS,
    parameter int  MAX_N  = MAX_WORDS,
    localparam int SET_W  = $clog2(N_SETS),
    localparam int IDX_W  = $clog2(MAX_N),
    localparam int LEN_W  = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_layer,
    input  logic [SET_W-1:0] req_set,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             req_err,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [IDX_W-1:0] b_idx,
    output logic             b_last,
    output logic [1:0]       rd_layer,
    output logic [SET_W-1:0] rd_set,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [WIDTH-1:0] rd_data
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]       state;
    logic [1:0]       layer_q;
    logic [SET_W-1:0] set_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] data_q;
    logic             req_err_q;
    logic             req_ok;
    logic             at_last;

    always_comb begin
        req_ok  = (req_len != '0)
                  && (int'(req_len) <= LAYER_LEN[req_layer])
                  && (int'(req_set) < N_SETS);
        at_last = (cnt == len_q - LEN_W'(1));
    end

    // The fetch address always points at the word to load on the next edge:
    // word 0 of the incoming request, or the word after the one presented.
    always_comb begin
        rd_layer = req_layer;
        rd_set   = req_set;
        rd_idx   = '0;
        if (state == ST_STREAM) begin
            rd_layer = layer_q;
            rd_set   = set_q;
            rd_idx   = cnt[IDX_W-1:0] + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            layer_q   <= '0;
            set_q     <= '0;
            len_q     <= '0;
            cnt       <= '0;
            data_q    <= '0;
            req_err_q <= 1'b0;
        end else begin
            req_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            layer_q <= req_layer;
                            set_q   <= req_set;
                            len_q   <= req_len;
                            cnt     <= '0;
                            data_q  <= rd_data;
                            state   <= ST_STREAM;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (b_ready) begin
                        if (at_last) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt    <= cnt + LEN_W'(1);
                            data_q <= rd_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign req_err   = req_err_q;
    assign b_valid   = (state == ST_STREAM);
    assign b_data    = data_q;
    assign b_idx     = cnt[IDX_W-1:0];
    assign b_last    = (state == ST_STREAM) && at_last;

endmodule

// File: rtl/bias_bank.sv
// Writable bias store for the GAN datapath: N_SETS bias sets per layer with a
// host write port and a streaming read port. BIAS_PRELOAD_EN selects trained reset contents.
module bias_bank
    import bias_pkg::*;
#(
    parameter int  WIDTH    = BIAS_W,
    parameter int  N_LAYERS = NUM_LAYERS,
    parameter int  N_SETS   = NUM_SETS,
    parameter int  MAX_N    = MAX_WORDS,
    localparam int SET_W    = $clog2(N_SETS),
    localparam int IDX_W    = $clog2(MAX_N),
    localparam int LEN_W    = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_layer,
    input  logic [SET_W-1:0] wr_set,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_err,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_layer,
    input  logic [SET_W-1:0] req_set,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_err,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [IDX_W-1:0] b_idx,
    output logic             b_last
);

    logic [WIDTH-1:0] mem     [N_LAYERS][N_SETS][MAX_N];
    logic [WIDTH-1:0] rst_mem [N_LAYERS][N_SETS][MAX_N];
    logic             wr_ok;
    logic             wr_err_q;
    logic [1:0]       rd_layer;
    logic [SET_W-1:0] rd_set;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;

    for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
        for (genvar s = 0; s < N_SETS; s++) begin : g_set
            for (genvar i = 0; i < MAX_N; i++) begin : g_word
`ifdef BIAS_PRELOAD_EN
                localparam logic [WIDTH-1:0] RST_VAL =
                    (s == 0) ? WIDTH'(BIAS_SET0[l][i]) :
                    (s == 1) ? WIDTH'(BIAS_SET1[l][i]) : '0;
`else
                localparam logic [WIDTH-1:0] RST_VAL = '0;
`endif
                assign rst_mem[l][s][i] = RST_VAL;
            end
        end
    end

    always_comb begin
        wr_ok = wr_en
                && (int'(wr_idx) < LAYER_LEN[wr_layer])
                && (int'(wr_set) < N_SETS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= rst_mem;
        end else if (wr_ok) begin
            mem[wr_layer][wr_set][wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en && !wr_ok;
        end
    end

    assign wr_err = wr_err_q;

    // Reads see the pre-edge contents, so a write and a fetch of the same
    // word on one edge deliver the old value to the stream.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < MAX_N) begin
            rd_data = mem[rd_layer][rd_set][rd_idx];
        end
    end

    bias_stream_fsm #(
        .WIDTH  (WIDTH),
        .N_SETS (N_SETS),
        .MAX_N  (MAX_N)
    ) u_stream (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_layer (req_layer),
        .req_set   (req_set),
        .req_len   (req_len),
        .req_ready (req_ready),
        .req_err   (req_err),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_idx     (b_idx),
        .b_last    (b_last),
        .rd_layer  (rd_layer),
        .rd_set    (rd_set),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_bias_bank.sv
// Directed scoreboard bench for bias_bank: writes, rejected writes/requests,
// backpressured streams with mid-stream writes, and asynchronous reset.
module tb_bias_bank;
    import bias_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_layer = '0;
    logic [1:0]  wr_set = '0;
    logic [3:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;
    logic        wr_err;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_layer = '0;
    logic [1:0]  req_set = '0;
    logic [4:0]  req_len = '0;
    logic        req_err;
    logic        b_valid;
    logic        b_ready = 1'b1;
    logic [31:0] b_data;
    logic [3:0]  b_idx;
    logic        b_last;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    localparam int TB_LEN [4] = '{3, 9, 3, 1};
    localparam bit PAT [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] NEW2 = 32'h0BADC0DE;
    localparam logic [31:0] NEW5 = 32'h00C0FFEE;

    beat_t       sb[$];
    logic [31:0] model [4][4][9];
    int          n_checks = 0;
    int          n_errors = 0;

    bias_bank dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_layer(wr_layer), .wr_set(wr_set), .wr_idx(wr_idx),
        .wr_data(wr_data), .wr_err(wr_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_layer(req_layer),
        .req_set(req_set), .req_len(req_len), .req_err(req_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_idx(b_idx),
        .b_last(b_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int l = 0; l < 4; l++)
            for (int s = 0; s < 4; s++)
                for (int i = 0; i < 9; i++) begin
`ifdef BIAS_PRELOAD_EN
                    model[l][s][i] = (s == 0) ? 32'(BIAS_SET0[l][i]) :
                                     (s == 1) ? 32'(BIAS_SET1[l][i]) : 32'h0;
`else
                    model[l][s][i] = 32'h0;
`endif
                end
    endfunction

    task automatic do_write(input int l, input int s, input int i, input logic [31:0] d);
        logic err;
        err = !(i < TB_LEN[l]);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_layer = 2'(l); wr_set = 2'(s); wr_idx = 4'(i); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("wr_err", {63'h0, wr_err}, {63'h0, err});
        if (!err) model[l][s][i] = d;
    endtask

    task automatic do_request(input int l, input int s, input int len);
        @(posedge clk); #1;
        req_valid = 1'b1; req_layer = 2'(l); req_set = 2'(s); req_len = 5'(len);
    endtask

    task automatic req_reject(input int l, input int s, input int len);
        do_request(l, s, len);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("req_err", {63'h0, req_err}, 64'h1);
        chk("no_valid_on_reject", {62'h0, req_ready, b_valid}, 64'h2);
    endtask

    task automatic push_stream(input int l, input int s, input int len);
        for (int k = 0; k < len; k++)
            sb.push_back('{data: model[l][s][k], idx: 4'(k), last: (k == len - 1)});
    endtask

    // Drains the scoreboard; toggle applies the 1,0,0,1 ready pattern with
    // word 0 landing on the first stall slot, mid_write injects idx-2/idx-5 writes.
    task automatic collect(input bit toggle, input bit mid_write, input int l, input int s);
        int    c = 0;
        int    guard = 0;
        int    wphase = 0;
        bit    first = 1'b1;
        bit    prev_stall = 1'b0;
        beat_t prev;
        beat_t exp_b;
        prev = '0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            wr_en     = 1'b0;
            b_ready   = 1'b1;
            if (b_valid) begin
                if (toggle) b_ready = PAT[(c + 1) % 4];
                if (mid_write && b_idx == 4'd2 && !b_ready && wphase < 2) begin
                    wr_en = 1'b1; wr_layer = 2'(l); wr_set = 2'(s);
                    if (wphase == 0) begin
                        wr_idx = 4'd2; wr_data = NEW2; model[l][s][2] = NEW2;
                    end else begin
                        wr_idx = 4'd5; wr_data = NEW5; model[l][s][5] = NEW5;
                        foreach (sb[q]) if (sb[q].idx == 4'd5) sb[q].data = NEW5;
                    end
                    wphase++;
                end
                c++;
            end
            @(negedge clk);
            if (first) begin
                chk("first_word_latency", {63'h0, b_valid}, 64'h1);
                first = 1'b0;
            end
            if (b_valid) begin
                if (prev_stall) chk("stall_hold", 64'({b_data, b_idx, b_last}), 64'(prev));
                if (b_ready) begin
                    exp_b = sb.pop_front();
                    chk("beat", 64'({b_data, b_idx, b_last}), 64'(exp_b));
                end
                prev_stall = !b_ready;
                prev       = {b_data, b_idx, b_last};
            end else begin
                prev_stall = 1'b0;
            end
            guard++;
        end
        chk("stream_drained", 64'(sb.size()), 64'h0);
        if (mid_write) chk("mid_stream_writes", 64'(wphase), 64'h2);
        @(posedge clk); #1;
        wr_en   = 1'b0;
        b_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_stream", {62'h0, req_ready, b_valid}, 64'h2);
        sb.delete();
    endtask

    initial begin
        bit found;
        model_reset();
        #12;
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_req_err", {63'h0, req_err}, 64'h0);
        chk("rst_wr_err", {63'h0, wr_err}, 64'h0);
        chk("rst_b_valid", {63'h0, b_valid}, 64'h0);
        chk("rst_b_data", {32'h0, b_data}, 64'h0);
        chk("rst_b_idx", {60'h0, b_idx}, 64'h0);
        chk("rst_b_last", {63'h0, b_last}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef BIAS_PRELOAD_EN
        do_write(0, 0, 0, 32'h01A1B252);
        do_write(0, 0, 1, 32'h00EF368B);
        do_write(0, 0, 2, 32'h00414304);
`endif
        // G_L2 set 0 trained values, b_ready held high
        sb.push_back('{data: 32'h01A1B252, idx: 4'd0, last: 1'b0});
        sb.push_back('{data: 32'h00EF368B, idx: 4'd1, last: 1'b0});
        sb.push_back('{data: 32'h00414304, idx: 4'd2, last: 1'b1});
        do_request(0, 0, 3);
        collect(1'b0, 1'b0, 0, 0);

        do_write(3, 2, 0, 32'hFF43FBB5);
        sb.push_back('{data: 32'hFF43FBB5, idx: 4'd0, last: 1'b1});
        do_request(3, 2, 1);
        collect(1'b0, 1'b0, 3, 2);

        do_write(3, 2, 1, 32'h12345678);
        req_reject(0, 0, 4);
        req_reject(3, 2, 0);
        req_reject(3, 0, 2);
        push_stream(3, 2, 1);
        do_request(3, 2, 1);
        collect(1'b0, 1'b0, 3, 2);

        for (int k = 0; k < 9; k++) do_write(1, 1, k, $urandom);
        push_stream(1, 1, 9);
        do_request(1, 1, 9);
        collect(1'b1, 1'b1, 1, 1);

        // Back-to-back check on D_L2 with all three words written
        do_write(2, 3, 0, 32'h7FFFFFFF);
        do_write(2, 3, 1, 32'h80000000);
        do_write(2, 3, 2, 32'h00000001);
        push_stream(2, 3, 3);
        do_request(2, 3, 3);
        collect(1'b0, 1'b0, 2, 3);

        // Reset while word 4 of G_L3 set 0 is presented
        do_request(1, 0, 9);
        found = 1'b0;
        for (int g = 0; g < 30 && !found; g++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            b_ready   = 1'b1;
            @(negedge clk);
            if (b_valid && b_idx == 4'd4) found = 1'b1;
        end
        chk("reached_word4", {63'h0, found}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_b_valid", {63'h0, b_valid}, 64'h0);
        chk("async_rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("async_rst_b_last", {63'h0, b_last}, 64'h0);
        chk("async_rst_b_data", {32'h0, b_data}, 64'h0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        push_stream(1, 1, 9);
        do_request(1, 1, 9);
        collect(1'b1, 1'b0, 1, 1);
        push_stream(3, 2, 1);
        do_request(3, 2, 1);
        collect(1'b0, 1'b0, 3, 2);
        push_stream(2, 3, 3);
        do_request(2, 3, 3);
        collect(1'b0, 1'b0, 2, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
